// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: byte sink for the Wrapper's UART handshake.
// Buffers accepted bytes in a small circular FIFO and shifts them out as
// 8N1 frames (start bit, 8 data bits LSB first, stop bit) at a fixed baud.
module uart_tx_serializer #(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic [7:0]                    UART_TX,
    input  logic                          UART_TX_valid,
    output logic                          UART_TX_ready,
    output logic                          TX,
    output logic                          TX_busy,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_count
);

    localparam int BAUD_DIV = CLK_FREQ_HZ / BAUD;
    localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BAUD_DIV - 1);
    localparam logic [PTR_W:0]   COUNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bitIdx_q, bitIdx_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;

    logic [7:0]         fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wrPtr_q, rdPtr_q;
    logic [PTR_W:0]     count_q;

    logic               push;
    logic               pop;
    logic               lastTick;
    logic               fifoNotEmpty;

    assign lastTick     = (cnt_q == CNT_LAST);
    assign fifoNotEmpty = (count_q != '0);
    assign push         = UART_TX_valid && UART_TX_ready;
    assign pop          = fifoNotEmpty && ((state_q == IDLE) || ((state_q == STOP) && lastTick));

    // Byte storage; contents are don't-care while the count says empty, so no reset.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifoMem[wrPtr_q] <= UART_TX;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Frame state register, including the registered line driver.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bitIdx_q <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitIdx_q <= bitIdx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
        end
    end

    // Next-state logic: walk start, data and stop bits, each held for BAUD_DIV cycles.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitIdx_d = bitIdx_q;
        shift_d  = shift_q;
        case (state_q)
            IDLE: begin
                if (fifoNotEmpty) begin
                    shift_d = fifoMem[rdPtr_q];
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (lastTick) begin
                    cnt_d    = '0;
                    bitIdx_d = '0;
                    state_d  = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (lastTick) begin
                    cnt_d    = '0;
                    shift_d  = {1'b0, shift_q[7:1]};
                    bitIdx_d = bitIdx_q + 3'd1;
                    if (bitIdx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (lastTick) begin
                    cnt_d = '0;
                    if (fifoNotEmpty) begin
                        shift_d = fifoMem[rdPtr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode: line level follows the upcoming state so TX comes straight from a flop.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        UART_TX_ready = RESET_N && (count_q != COUNT_FULL);
        TX_busy       = (state_q != IDLE) || fifoNotEmpty;
        TX            = tx_q;
        FIFO_count    = count_q;
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: drives the byte handshake and compares the serial
// line, busy flag, FIFO count and ready against a frame-level model that
// tracks a byte queue and the start edge of the frame on the wire.
module tb_uart_tx_serializer;

    localparam int CLK_FREQ_HZ = 1000;
    localparam int BAUD        = 100;
    localparam int DIV         = CLK_FREQ_HZ / BAUD;
    localparam int DEPTH       = 4;

    logic       clk = 1'b0;
    logic       resetN = 1'b1;
    logic [7:0] dataIn = 8'h00;
    logic       validIn = 1'b0;
    logic       readyOut;
    logic       txOut;
    logic       busyOut;
    logic [2:0] countOut;

    int testsRun = 0;
    int testsFailed = 0;

    logic [7:0] modelQ[$];
    bit         frameActive = 1'b0;
    logic [7:0] frameByte = 8'h00;
    int         frameStart = 0;
    int         edgeNum = 0;
    bit         lastAccepted = 1'b0;

    uart_tx_serializer #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .BAUD(BAUD),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .CLK(clk),
        .RESET_N(resetN),
        .UART_TX(dataIn),
        .UART_TX_valid(validIn),
        .UART_TX_ready(readyOut),
        .TX(txOut),
        .TX_busy(busyOut),
        .FIFO_count(countOut)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d expected %0d (edge %0d)", tag, observed, expected, edgeNum);
        end
    endtask

    task automatic clearModel();
        modelQ.delete();
        frameActive = 1'b0;
    endtask

    // One rising edge of the reference: finish a 10-bit frame, start the next, take a new byte.
    task automatic modelEdge();
        bit readyNow;
        edgeNum++;
        lastAccepted = 1'b0;
        if (resetN) begin
            readyNow = (modelQ.size() != DEPTH);
            if (frameActive && (edgeNum - frameStart == 10 * DIV)) begin
                frameActive = 1'b0;
            end
            if (!frameActive && modelQ.size() != 0) begin
                frameByte   = modelQ.pop_front();
                frameActive = 1'b1;
                frameStart  = edgeNum;
            end
            if (validIn && readyNow) begin
                modelQ.push_back(dataIn);
                lastAccepted = 1'b1;
            end
        end
    endtask

    function automatic int expectedTx();
        int bitPos;
        if (!frameActive) return 1;
        bitPos = (edgeNum - frameStart) / DIV;
        if (bitPos == 0) return 0;
        if (bitPos <= 8) return int'(frameByte[bitPos-1]);
        return 1;
    endfunction

    task automatic compareAll();
        checkOutput("tx", int'(txOut), expectedTx());
        checkOutput("busy", int'(busyOut), int'(frameActive || modelQ.size() != 0));
        checkOutput("count", int'(countOut), modelQ.size());
        checkOutput("ready", int'(readyOut), int'(resetN && modelQ.size() != DEPTH));
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d);
        validIn = v;
        dataIn  = d;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        compareAll();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00);
    endtask

    // Reset pulled low between edges; outputs must react before the next clock edge.
    task automatic doAsyncReset(input int holdCycles);
        #2 resetN = 1'b0;
        #1 clearModel();
        compareAll();
        for (int i = 0; i < holdCycles; i++) applyStimulus(1'b0, 8'h00);
        @(negedge clk);
        resetN = 1'b1;
        #1 checkOutput("readyAfterRelease", int'(readyOut), 1);
    endtask

    // Offers bytes in order with valid held high, advancing only when the model accepts.
    task automatic pushHeld(input logic [7:0] bytes[$], input int budget, input string tag);
        int idx = 0;
        int cyc = 0;
        while (idx < bytes.size() && cyc < budget) begin
            applyStimulus(1'b1, bytes[idx]);
            if (lastAccepted) idx++;
            cyc++;
        end
        validIn = 1'b0;
        checkOutput(tag, idx, bytes.size());
    endtask

    initial begin
        logic [7:0] seq[$];
        int guard;

        $display("[TB] start, BAUD_DIV=%0d FIFO_DEPTH=%0d", DIV, DEPTH);
        #1 resetN = 1'b0;
        #1 clearModel();
        compareAll();
        idleCycles(3);
        resetN = 1'b1;
        idleCycles(2);

        $display("[TB] single byte 0x55");
        applyStimulus(1'b1, 8'h55);
        idleCycles(110);

        $display("[TB] back-to-back 0xA5, 0x3C");
        applyStimulus(1'b1, 8'hA5);
        applyStimulus(1'b1, 8'h3C);
        idleCycles(210);

        $display("[TB] overflow with six held bytes");
        seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        pushHeld(seq, 400, "overflowAccepted");
        idleCycles(6 * 10 * DIV + 20);

        $display("[TB] valid pulse while full");
        seq = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hE7};
        pushHeld(seq, 20, "fillAccepted");
        checkOutput("fullCount", int'(countOut), DEPTH);
        applyStimulus(1'b1, 8'hFF);
        checkOutput("fullRefused", int'(countOut), DEPTH);
        idleCycles(5 * 10 * DIV + 20);

        $display("[TB] reset during data bit 3");
        applyStimulus(1'b1, 8'hC3);
        applyStimulus(1'b1, 8'h5A);
        applyStimulus(1'b1, 8'h0F);
        guard = 0;
        while (!(frameActive && (edgeNum - frameStart) == 4 * DIV + 4) && guard < 200) begin
            applyStimulus(1'b0, 8'h00);
            guard++;
        end
        checkOutput("midFrameReached", int'(frameActive && (edgeNum - frameStart) == 4 * DIV + 4), 1);
        checkOutput("bufferedBeforeReset", int'(countOut), 2);
        doAsyncReset(3);
        idleCycles(150);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 2) == 0), 8'($urandom));
        end
        idleCycles(DEPTH * 10 * DIV + 120);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
